// File: rtl/wb_cache_controller_if.sv
// CPU-side and memory-side handshake bundle of the write-back cache controller.
// The master modport is the environment (CPU plus memory), the slave modport is the controller.
interface wb_cache_controller_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADR_WIDTH  = 32
);
    logic                  req_cpu2cc;
    logic                  rdwr_cpu2cc;
    logic [ADR_WIDTH-1:0]  adr_cpu2cc;
    logic [WORD_WIDTH-1:0] dat_cpu2cc;
    logic                  ack_cc2cpu;
    logic [WORD_WIDTH-1:0] dat_cc2cpu;
    logic                  busy_cc;
    logic                  req_cc2mem;
    logic                  rdwr_cc2mem;
    logic [ADR_WIDTH-1:0]  adr_cc2mem;
    logic [WORD_WIDTH-1:0] dat_cc2mem;
    logic                  ack_mem2cc;
    logic [WORD_WIDTH-1:0] dat_mem2cc;

    modport master (
        output req_cpu2cc, rdwr_cpu2cc, adr_cpu2cc, dat_cpu2cc, ack_mem2cc, dat_mem2cc,
        input  ack_cc2cpu, dat_cc2cpu, busy_cc, req_cc2mem, rdwr_cc2mem, adr_cc2mem, dat_cc2mem
    );

    modport slave (
        input  req_cpu2cc, rdwr_cpu2cc, adr_cpu2cc, dat_cpu2cc, ack_mem2cc, dat_mem2cc,
        output ack_cc2cpu, dat_cc2cpu, busy_cc, req_cc2mem, rdwr_cc2mem, adr_cc2mem, dat_cc2mem
    );
endinterface

// File: rtl/wb_cache_controller.sv
// N-way set-associative write-back/write-allocate cache controller with true-LRU ages,
// dirty-victim write-back and critical-word-first wrapping refill.
module wb_cache_controller #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned ADR_WIDTH   = 32,
    parameter int unsigned WAY_NUM     = 4,
    parameter int unsigned CACHE_LINES = 128,
    parameter int unsigned WORD_NUM    = 4
) (
    input logic                 clk,
    input logic                 rst,
    wb_cache_controller_if.slave bus
);
    localparam int unsigned BYTE_OFS = $clog2(WORD_WIDTH / 8);
    localparam int unsigned WORD_OFS = $clog2(WORD_NUM);
    localparam int unsigned INDEX_W  = $clog2(CACHE_LINES);
    localparam int unsigned TAG_W    = ADR_WIDTH - INDEX_W - WORD_OFS - BYTE_OFS;
    localparam int unsigned AGE_W    = $clog2(WAY_NUM);

    typedef enum logic [2:0] {StIdle, StLookup, StHit, StWback, StRefill} state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0]      tag_mem  [WAY_NUM][CACHE_LINES];
    logic [WORD_WIDTH-1:0] data_mem [WAY_NUM][CACHE_LINES][WORD_NUM];
    logic [WAY_NUM-1:0]    valid_q  [CACHE_LINES];
    logic [WAY_NUM-1:0]    dirty_q  [CACHE_LINES];
    logic [AGE_W-1:0]      age_q    [WAY_NUM][CACHE_LINES];

    logic                  rdwr_q;
    logic [TAG_W-1:0]      tag_q;
    logic [INDEX_W-1:0]    index_q;
    logic [WORD_OFS-1:0]   word_q;
    logic [WORD_WIDTH-1:0] wdat_q;
    logic [AGE_W-1:0]      way_q;
    logic [WORD_OFS-1:0]   cnt_q;
    logic                  first_q;

    logic                  hit;
    logic [AGE_W-1:0]      hit_way;
    logic [AGE_W-1:0]      victim;
    logic                  victim_dirty;
    logic [WORD_OFS-1:0]   cnt_inc;
    logic                  wb_last;
    logic                  refill_last;
    logic                  lru_en;
    logic                  unused_byte_ofs;

    assign unused_byte_ofs = ^bus.adr_cpu2cc[BYTE_OFS-1:0];
    assign cnt_inc         = cnt_q + WORD_OFS'(1);
    assign wb_last         = (cnt_q == WORD_OFS'(WORD_NUM - 1));
    assign refill_last     = (cnt_inc == word_q);
    assign lru_en          = (state_q == StHit) ||
                             (state_q == StRefill && bus.ack_mem2cc && first_q);

    // Descending loops let the lowest-index candidate win.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (valid_q[index_q][w] && tag_mem[w][index_q] == tag_q) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
        victim = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (age_q[w][index_q] == AGE_W'(WAY_NUM - 1)) victim = AGE_W'(w);
        end
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (!valid_q[index_q][w]) victim = AGE_W'(w);
        end
        victim_dirty = valid_q[index_q][victim] && dirty_q[index_q][victim];
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.req_cpu2cc) state_d = StLookup;
            StLookup: state_d = hit ? StHit : (victim_dirty ? StWback : StRefill);
            StHit:    state_d = StIdle;
            StWback:  if (bus.ack_mem2cc && wb_last) state_d = StRefill;
            StRefill: if (bus.ack_mem2cc && refill_last) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ack_cc2cpu  = 1'b0;
        bus.dat_cc2cpu  = '0;
        bus.busy_cc     = (state_q != StIdle);
        bus.req_cc2mem  = 1'b0;
        bus.rdwr_cc2mem = 1'b0;
        bus.adr_cc2mem  = '0;
        bus.dat_cc2mem  = '0;
        unique case (state_q)
            StHit: begin
                bus.ack_cc2cpu = 1'b1;
                if (!rdwr_q) bus.dat_cc2cpu = data_mem[way_q][index_q][word_q];
            end
            StWback: begin
                bus.req_cc2mem  = 1'b1;
                bus.rdwr_cc2mem = 1'b1;
                bus.adr_cc2mem  = {tag_mem[way_q][index_q], index_q, cnt_q, {BYTE_OFS{1'b0}}};
                bus.dat_cc2mem  = data_mem[way_q][index_q][cnt_q];
            end
            StRefill: begin
                bus.req_cc2mem = 1'b1;
                bus.adr_cc2mem = {tag_q, index_q, cnt_q, {BYTE_OFS{1'b0}}};
                if (first_q && bus.ack_mem2cc) begin
                    bus.ack_cc2cpu = 1'b1;
                    if (!rdwr_q) bus.dat_cc2cpu = bus.dat_mem2cc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            for (int s = 0; s < CACHE_LINES; s++) begin
                for (int w = 0; w < WAY_NUM; w++) age_q[w][s] <= AGE_W'(w);
            end
            rdwr_q  <= 1'b0;
            tag_q   <= '0;
            index_q <= '0;
            word_q  <= '0;
            wdat_q  <= '0;
            way_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_cpu2cc) begin
                        rdwr_q  <= bus.rdwr_cpu2cc;
                        tag_q   <= bus.adr_cpu2cc[ADR_WIDTH-1 -: TAG_W];
                        index_q <= bus.adr_cpu2cc[BYTE_OFS+WORD_OFS +: INDEX_W];
                        word_q  <= bus.adr_cpu2cc[BYTE_OFS +: WORD_OFS];
                        wdat_q  <= bus.dat_cpu2cc;
                    end
                end
                StLookup: begin
                    way_q   <= hit ? hit_way : victim;
                    cnt_q   <= (!hit && victim_dirty) ? '0 : word_q;
                    first_q <= 1'b1;
                end
                StHit: begin
                    if (rdwr_q) dirty_q[index_q][way_q] <= 1'b1;
                end
                StWback: begin
                    if (bus.ack_mem2cc) begin
                        cnt_q <= cnt_inc;
                        if (wb_last) begin
                            dirty_q[index_q][way_q] <= 1'b0;
                            cnt_q                   <= word_q;
                        end
                    end
                end
                StRefill: begin
                    if (bus.ack_mem2cc) begin
                        cnt_q   <= cnt_inc;
                        first_q <= 1'b0;
                        if (first_q) begin
                            valid_q[index_q][way_q] <= 1'b1;
                            dirty_q[index_q][way_q] <= rdwr_q;
                        end
                    end
                end
                default: ;
            endcase
            // Ages younger than the accessed way grow older; accessed way becomes youngest.
            if (lru_en) begin
                for (int w = 0; w < WAY_NUM; w++) begin
                    if (AGE_W'(w) == way_q) begin
                        age_q[w][index_q] <= '0;
                    end else if (age_q[w][index_q] < age_q[way_q][index_q]) begin
                        age_q[w][index_q] <= age_q[w][index_q] + AGE_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state_q == StHit && rdwr_q) begin
            data_mem[way_q][index_q][word_q] <= wdat_q;
        end
        if (rst && state_q == StRefill && bus.ack_mem2cc) begin
            data_mem[way_q][index_q][cnt_q] <= (first_q && rdwr_q) ? wdat_q : bus.dat_mem2cc;
            if (first_q) tag_mem[way_q][index_q] <= tag_q;
        end
    end
endmodule

// File: tb/tb_wb_cache_controller.sv
// Directed bench for wb_cache_controller: a 4-way/128-set/4-word and a 2-way/16-set/8-word
// instance share one CPU driver and one memory responder, selected by cfg_sel.
module tb_wb_cache_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_cache_controller_if #(.WORD_WIDTH(32), .ADR_WIDTH(32)) bus_a ();
    wb_cache_controller_if #(.WORD_WIDTH(32), .ADR_WIDTH(32)) bus_b ();

    wb_cache_controller #(
        .WORD_WIDTH(32), .ADR_WIDTH(32), .WAY_NUM(4), .CACHE_LINES(128), .WORD_NUM(4)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    wb_cache_controller #(
        .WORD_WIDTH(32), .ADR_WIDTH(32), .WAY_NUM(2), .CACHE_LINES(16), .WORD_NUM(8)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    logic        cfg_sel = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_rdwr = 1'b0;
    logic [31:0] cpu_adr = '0;
    logic [31:0] cpu_dat = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_dat = '0;

    assign bus_a.req_cpu2cc  = cpu_req && !cfg_sel;
    assign bus_b.req_cpu2cc  = cpu_req && cfg_sel;
    assign bus_a.rdwr_cpu2cc = cpu_rdwr;
    assign bus_b.rdwr_cpu2cc = cpu_rdwr;
    assign bus_a.adr_cpu2cc  = cpu_adr;
    assign bus_b.adr_cpu2cc  = cpu_adr;
    assign bus_a.dat_cpu2cc  = cpu_dat;
    assign bus_b.dat_cpu2cc  = cpu_dat;
    assign bus_a.ack_mem2cc  = mem_ack && !cfg_sel;
    assign bus_b.ack_mem2cc  = mem_ack && cfg_sel;
    assign bus_a.dat_mem2cc  = mem_dat;
    assign bus_b.dat_mem2cc  = mem_dat;

    logic        ack, busy, mreq, mrdwr;
    logic [31:0] rdat, madr, mdat;
    assign ack   = cfg_sel ? bus_b.ack_cc2cpu  : bus_a.ack_cc2cpu;
    assign busy  = cfg_sel ? bus_b.busy_cc     : bus_a.busy_cc;
    assign rdat  = cfg_sel ? bus_b.dat_cc2cpu  : bus_a.dat_cc2cpu;
    assign mreq  = cfg_sel ? bus_b.req_cc2mem  : bus_a.req_cc2mem;
    assign mrdwr = cfg_sel ? bus_b.rdwr_cc2mem : bus_a.rdwr_cc2mem;
    assign madr  = cfg_sel ? bus_b.adr_cc2mem  : bus_a.adr_cc2mem;
    assign mdat  = cfg_sel ? bus_b.dat_cc2mem  : bus_a.dat_cc2mem;

    typedef struct packed {
        logic        rdwr;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t       xfer_log[$];
    logic [31:0] mem_store[int unsigned];

    int n_vec = 0;
    int n_err = 0;
    int ways, words, lines, lbytes, stride;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Acks every other cycle; read data comes from the store or the address pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mreq && !mem_ack) begin
                mem_ack = 1'b1;
                xfer_log.push_back('{rdwr: mrdwr, adr: madr, dat: mdat});
                if (mrdwr) mem_store[madr] = mdat;
                else mem_dat = mem_store.exists(madr) ? mem_store[madr] : pattern(madr);
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    task automatic set_cfg(input logic s);
        cfg_sel = s;
        ways    = s ? 2 : 4;
        words   = s ? 8 : 4;
        lines   = s ? 16 : 128;
        lbytes  = words * 4;
        stride  = lines * lbytes;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) check($sformatf("c%0d idle timeout", cfg_sel), 32'(busy), 32'd0);
    endtask

    // Called at a negedge; returns read data and negedges counted until ack was seen.
    task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output int cyc);
        wait_idle();
        cpu_req  = 1'b1;
        cpu_rdwr = wr;
        cpu_adr  = a;
        cpu_dat  = d;
        cyc      = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack && cyc < 200);
        if (!ack) check($sformatf("c%0d ack timeout 0x%08h", cfg_sel, a), 32'(ack), 32'd1);
        rd      = rdat;
        cpu_req = 1'b0;
    endtask

    task automatic check_refill(input string tag, input logic [31:0] a, input int start);
        logic [31:0] base;
        int          w0;
        base = a & ~(lbytes - 1);
        w0   = int'((a % lbytes) / 4);
        if (xfer_log.size() >= start + words) begin
            for (int i = 0; i < words; i++) begin
                check($sformatf("c%0d %s rd%0d rdwr", cfg_sel, tag, i),
                      32'(xfer_log[start+i].rdwr), 32'd0);
                check($sformatf("c%0d %s rd%0d adr", cfg_sel, tag, i),
                      xfer_log[start+i].adr, base + ((w0 + i) % words) * 4);
            end
        end else begin
            check($sformatf("c%0d %s log short", cfg_sel, tag), xfer_log.size(), start + words);
        end
    endtask

    task automatic run_scenarios();
        logic [31:0] rd;
        logic [31:0] a;
        int          cyc;

        // Cold read: critical word first, ack on the first memory ack, still busy after.
        xfer_log.delete();
        cpu_access(1'b0, 32'h48, 32'h0, rd, cyc);
        check($sformatf("c%0d cold data", cfg_sel), rd, pattern(32'h48));
        check($sformatf("c%0d cold ack cyc", cfg_sel), cyc, 2);
        check($sformatf("c%0d busy after ack", cfg_sel), 32'(busy), 32'd1);
        wait_idle();
        check($sformatf("c%0d cold xfers", cfg_sel), xfer_log.size(), words);
        check_refill("cold", 32'h48, 0);

        // Hit read: no traffic.
        xfer_log.delete();
        cpu_access(1'b0, 32'h44, 32'h0, rd, cyc);
        check($sformatf("c%0d hit data", cfg_sel), rd, pattern(32'h44));
        check($sformatf("c%0d hit cyc", cfg_sel), cyc, 2);
        wait_idle();
        check($sformatf("c%0d hit xfers", cfg_sel), xfer_log.size(), 0);

        // Write hit, then evict the dirty line.
        cpu_access(1'b1, 32'h40, 32'hDEAD_BEEF, rd, cyc);
        check($sformatf("c%0d wr cyc", cfg_sel), cyc, 2);
        cpu_access(1'b0, 32'h40, 32'h0, rd, cyc);
        check($sformatf("c%0d wr readback", cfg_sel), rd, 32'hDEAD_BEEF);
        wait_idle();
        check($sformatf("c%0d wr xfers", cfg_sel), xfer_log.size(), 0);
        for (int k = 1; k <= ways; k++) begin
            wait_idle();
            xfer_log.delete();
            a = 32'h40 + k * stride;
            cpu_access(1'b0, a, 32'h0, rd, cyc);
            check($sformatf("c%0d fill%0d data", cfg_sel, k), rd, pattern(a));
        end
        wait_idle();
        if (xfer_log.size() == 2 * words) begin
            for (int i = 0; i < words; i++) begin
                check($sformatf("c%0d wb%0d rdwr", cfg_sel, i), 32'(xfer_log[i].rdwr), 32'd1);
                check($sformatf("c%0d wb%0d adr", cfg_sel, i), xfer_log[i].adr, 32'h40 + i * 4);
                check($sformatf("c%0d wb%0d dat", cfg_sel, i), xfer_log[i].dat,
                      (i == 0) ? 32'hDEAD_BEEF : pattern(32'h40 + i * 4));
            end
            check_refill("evict", 32'h40 + ways * stride, words);
        end else begin
            check($sformatf("c%0d evict xfers", cfg_sel), xfer_log.size(), 2 * words);
        end

        // LRU in set 0: fill A.., re-touch A, miss on E must evict B.
        for (int k = 0; k < ways; k++) cpu_access(1'b0, k * stride + 4, 32'h0, rd, cyc);
        wait_idle();
        xfer_log.delete();
        cpu_access(1'b0, 32'h4, 32'h0, rd, cyc);
        wait_idle();
        check($sformatf("c%0d lru A rehit", cfg_sel), xfer_log.size(), 0);
        a = ways * stride + 4;
        cpu_access(1'b0, a, 32'h0, rd, cyc);
        check($sformatf("c%0d lru E data", cfg_sel), rd, pattern(a));
        wait_idle();
        check($sformatf("c%0d lru E xfers", cfg_sel), xfer_log.size(), words);
        check_refill("lruE", a, 0);
        xfer_log.delete();
        cpu_access(1'b0, 32'h4, 32'h0, rd, cyc);
        check($sformatf("c%0d lru A data", cfg_sel), rd, pattern(32'h4));
        for (int k = 2; k < ways; k++) cpu_access(1'b0, k * stride + 4, 32'h0, rd, cyc);
        wait_idle();
        check($sformatf("c%0d lru A,C.. hit", cfg_sel), xfer_log.size(), 0);
        cpu_access(1'b0, stride + 4, 32'h0, rd, cyc);
        wait_idle();
        check($sformatf("c%0d lru B missed", cfg_sel), xfer_log.size(), words);
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          g;

        set_cfg(1'b0);
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset req", 32'(mreq), 32'd0);
        check("reset dat", rdat, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        set_cfg(1'b0);
        run_scenarios();
        wait_idle();
        set_cfg(1'b1);
        run_scenarios();
        wait_idle();

        // Reset landing on the second refill ack abandons the transfer and clears valid bits.
        set_cfg(1'b0);
        xfer_log.delete();
        cpu_access(1'b0, 32'h3F0, 32'h0, rd, cyc);
        check("rst first data", rd, pattern(32'h3F0));
        g = 0;
        while (!(mem_ack && xfer_log.size() == 2) && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("rst 2nd ack seen", 32'(mem_ack), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst req_cc2mem", 32'(mreq), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst ack", 32'(ack), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        xfer_log.delete();
        cpu_access(1'b0, 32'h3F0, 32'h0, rd, cyc);
        check("rst reread data", rd, pattern(32'h3F0));
        wait_idle();
        check("rst reread misses", xfer_log.size(), words);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
